// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 inverse key schedule engine.
// Holds the round-constant table and the sequencer state encoding.
package aes_pkg;

    localparam int NR     = 10;
    localparam int KEY_W  = 128;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_EMIT
    } state_e;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel AES S-box lookups on a 32-bit word.
// Table byte 0 sits at the MSB end, so entry b starts at bit (255-b)*8.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    output logic [WORD_W-1:0] o_word
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    always_comb begin
        o_word = '0;
        for (int i = 0; i < 4; i++) begin
            o_word[8*i +: 8] = sbox(i_word[8*i +: 8]);
        end
    end

endmodule

// File: rtl/aes_inv_key_generation.sv
// AES-128 key schedule: expands forward to round key 10, then streams
// keys 10..0 back out through the inverse schedule, one per handshake.
module aes_inv_key_generation
    import aes_pkg::*;
(
    input  logic             i_aes_inv_key_generation_clk,
    input  logic             i_aes_inv_key_generation_rst,
    input  logic             i_aes_inv_key_generation_start,
    input  logic [KEY_W-1:0] i_aes_inv_key_generation_input_key,
    output logic             o_aes_inv_key_generation_busy,
    output logic [KEY_W-1:0] o_aes_inv_key_generation_round_key,
    output logic [3:0]       o_aes_inv_key_generation_round_idx,
    output logic             o_aes_inv_key_generation_valid,
    input  logic             i_aes_inv_key_generation_ready,
    output logic             o_aes_inv_key_generation_done
);

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [3:0]         idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic [WORD_W-1:0]  w0, w1, w2, w3;
    logic [WORD_W-1:0]  sw_sel, sw_in, sw_out;
    logic [7:0]         rc_fwd, rc_inv;
    logic [KEY_W-1:0]   key_fwd, key_inv;
    logic [WORD_W-1:0]  n0, n1, n2, n3;
    logic [WORD_W-1:0]  p0, p1, p2, p3;

    assign {w0, w1, w2, w3} = key_q;

    // One S-box bank serves both directions; RotWord is applied ahead of it.
    assign sw_sel = (state_q == ST_EMIT) ? (w3 ^ w2) : w3;
    assign sw_in  = {sw_sel[23:0], sw_sel[31:24]};

    aes_sub_word u_sub_word (
        .i_word (sw_in),
        .o_word (sw_out)
    );

    assign rc_fwd = rcon(idx_q + 4'd1);
    assign rc_inv = rcon(idx_q);

    assign n0 = w0 ^ sw_out ^ {rc_fwd, 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign key_fwd = {n0, n1, n2, n3};

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    assign p0 = w0 ^ sw_out ^ {rc_inv, 24'h0};
    assign key_inv = {p0, p1, p2, p3};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_aes_inv_key_generation_start) begin
                    key_d   = i_aes_inv_key_generation_input_key;
                    idx_d   = 4'd0;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                key_d = key_fwd;
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'(NR - 1)) begin
                    state_d = ST_EMIT;
                    valid_d = 1'b1;
                end
            end
            ST_EMIT: begin
                if (valid_q && i_aes_inv_key_generation_ready) begin
                    if (idx_q != 4'd0) begin
                        key_d = key_inv;
                        idx_d = idx_q - 4'd1;
                    end else begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_aes_inv_key_generation_clk or
                posedge i_aes_inv_key_generation_rst) begin
        if (i_aes_inv_key_generation_rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign o_aes_inv_key_generation_busy      = (state_q != ST_IDLE);
    assign o_aes_inv_key_generation_round_key = key_q;
    assign o_aes_inv_key_generation_round_idx = idx_q;
    assign o_aes_inv_key_generation_valid     = valid_q;
    assign o_aes_inv_key_generation_done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_generation.sv
// Self-checking bench for aes_inv_key_generation: GF(2^8)-derived S-box,
// forward-expansion reference, per-cycle compare plus directed scenarios.
module tb_aes_inv_key_generation;

    localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] in_key;
    logic         busy;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         valid;
    logic         ready;
    logic         done;

    int errs   = 0;
    int checks = 0;

    aes_inv_key_generation dut (
        .i_aes_inv_key_generation_clk       (clk),
        .i_aes_inv_key_generation_rst       (rst),
        .i_aes_inv_key_generation_start     (start),
        .i_aes_inv_key_generation_input_key (in_key),
        .o_aes_inv_key_generation_busy      (busy),
        .o_aes_inv_key_generation_round_key (round_key),
        .o_aes_inv_key_generation_round_idx (round_idx),
        .o_aes_inv_key_generation_valid     (valid),
        .i_aes_inv_key_generation_ready     (ready),
        .o_aes_inv_key_generation_done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference S-box built from GF(2^8) inversion and the affine map
    logic [7:0] sb [256];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        if (x == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                   ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Round key r of cipher key k by plain forward expansion
    function automatic logic [127:0] rk_of(input logic [127:0] k, input int r);
        logic [31:0] w [4];
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        for (int i = 1; i <= r; i++) begin
            t = subw({w[3][23:0], w[3][31:24]}) ^ {rc, 24'h0};
            w[0] = w[0] ^ t;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            rc = xtime(rc);
        end
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // Behavioural model: 0 idle, 1 expanding (cycles left), 2 emitting
    int           m_mode  = 0;
    int           m_wait  = 0;
    logic [3:0]   m_idx   = 4'd0;
    logic         m_valid = 1'b0;
    logic         m_busy  = 1'b0;
    logic         m_done  = 1'b0;
    logic [127:0] m_key   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_wait = 0; m_idx = 4'd0;
            m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            case (m_mode)
                0: if (start) begin
                    m_key = in_key; m_wait = 10; m_mode = 1; m_busy = 1'b1;
                end
                1: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_mode = 2; m_valid = 1'b1; m_idx = 4'd10;
                    end
                end
                default: if (ready) begin
                    if (m_idx > 0) m_idx = m_idx - 4'd1;
                    else begin
                        m_valid = 1'b0; m_busy = 1'b0;
                        m_done = 1'b1; m_mode = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("busy", 128'(busy), 128'(m_busy));
        chk("valid", 128'(valid), 128'(m_valid));
        chk("done", 128'(done), 128'(m_done));
        if (m_valid) begin
            chk("round_idx", 128'(round_idx), 128'(m_idx));
            chk("round_key", round_key, rk_of(m_key, int'(m_idx)));
        end
    end

    int n_done  = 0;
    int n_valid = 0;
    always @(negedge clk) begin
        if (done) n_done++;
        if (valid) n_valid++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [127:0] k);
        in_key = k;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        in_key = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_idx(input int idx);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (valid && round_idx == 4'(idx)) return;
        end
        checks++; errs++;
        $display("FAIL wait_idx%0d: timeout, no valid key at that index", idx);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 120; i++) begin
            tick();
            if (done) return;
        end
        checks++; errs++;
        $display("FAIL wait_done: timeout, done never pulsed");
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_valid"}, 128'(valid), 128'd0);
        chk({tag, "_done"}, 128'(done), 128'd0);
        chk({tag, "_idx"}, 128'(round_idx), 128'd0);
        chk({tag, "_key"}, round_key, 128'd0);
    endtask

    int d0, v0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        rst = 1'b1; start = 1'b0; ready = 1'b1; in_key = '0;
        repeat (2) tick();
        #1 chk_reset_outputs("por");
        tick();
        rst = 1'b0;

        // Pin the reference model to published values
        chk("m_fips10", rk_of(FIPS, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("m_fips9", rk_of(FIPS, 9), 128'hac7766f319fadc2128d12941575c006e);
        chk("m_fips1", rk_of(FIPS, 1), 128'ha0fafe1788542cb123a339392a6c7605);
        chk("m_fips0", rk_of(FIPS, 0), FIPS);
        chk("m_zero10", rk_of('0, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        chk("m_zero1", rk_of('0, 1), 128'h62636363626363636263636362636363);

        // FIPS key, ready held high
        tick();
        d0 = n_done; v0 = n_valid;
        pulse_start(FIPS);
        wait_idx(10);
        chk("fips_first_key", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        wait_done();
        tick(); #1;
        chk("fips_valid_cycles", 128'(n_valid - v0), 128'd11);
        chk("fips_done_count", 128'(n_done - d0), 128'd1);

        // Backpressure at idx 9
        pulse_start(FIPS);
        wait_idx(9);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_key", round_key, 128'hac7766f319fadc2128d12941575c006e);
            chk("bp_hold_idx", 128'(round_idx), 128'd9);
        end
        ready = 1'b1;
        wait_done();
        tick();

        // Start pulses while busy are ignored
        #1 d0 = n_done;
        tick();
        pulse_start(FIPS);
        repeat (3) tick();
        pulse_start({$urandom, $urandom, $urandom, $urandom});
        wait_idx(6);
        pulse_start({$urandom, $urandom, $urandom, $urandom});
        wait_done();
        repeat (3) tick();
        #1 chk("busy_start_done_count", 128'(n_done - d0), 128'd1);

        // Reset in the middle of emission
        tick();
        d0 = n_done;
        pulse_start(FIPS);
        wait_idx(5);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("mid_rst");
        tick();
        rst = 1'b0;
        repeat (4) tick();
        #1 chk("mid_rst_no_done", 128'(n_done - d0), 128'd0);
        tick();
        pulse_start(FIPS);
        wait_done();
        tick();

        // All-zero key
        pulse_start('0);
        wait_idx(1);
        chk("zero_idx1", round_key, 128'h62636363626363636263636362636363);
        wait_done();
        tick();

        // Random keys, random ready, stray start pulses
        for (int n = 0; n < 20; n++) begin
            pulse_start({$urandom, $urandom, $urandom, $urandom});
            for (int c = 0; c < 300; c++) begin
                ready  = 1'($urandom_range(0, 1));
                start  = ($urandom_range(0, 7) == 0);
                in_key = {$urandom, $urandom, $urandom, $urandom};
                tick();
                if (done) break;
                if (c == 299) begin
                    checks++; errs++;
                    $display("FAIL rand_run%0d: timeout, done never pulsed", n);
                end
            end
            start = 1'b0;
            ready = 1'b1;
            repeat (2) tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_generation.md
Name: aes_inv_key_generation

Overview:
Sequential key-schedule engine for the AES-128 decryption datapath. Accepts the cipher key and expands it forward internally to round key 10. It then streams round keys in reverse order (10 down to 0) using the inverse key schedule, one key per valid/ready handshake. This gives the decrypt rounds their keys in consumption order without storing all 11 keys.

Parameters:
NR, 10, number of AES-128 rounds; fixed, not user-tunable.

Ports:
i_aes_inv_key_generation_clk  input  1  clock, rising-edge
i_aes_inv_key_generation_rst  input  1  asynchronous, active-high reset
i_aes_inv_key_generation_start  input  1  start pulse; sampled only in IDLE
i_aes_inv_key_generation_input_key  input  128  cipher key (round key 0); word 0 = bits [127:96]
o_aes_inv_key_generation_busy  output  1  high in EXPAND and EMIT
o_aes_inv_key_generation_round_key  output  128  current round key
o_aes_inv_key_generation_round_idx  output  4  index of o_..._round_key (10..0)
o_aes_inv_key_generation_valid  output  1  round_key/round_idx valid
i_aes_inv_key_generation_ready  input  1  consumer accepts when valid & ready
o_aes_inv_key_generation_done  output  1  one-cycle pulse after key 0 is accepted

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, internal key and round counter 0.
- Word convention: W0..W3 is the current key, W0 = [127:96]. RotWord is a left byte rotate. SubWord is the FIPS-197 S-box on each byte. Rcon(r) = {01,02,04,08,10,20,40,80,1b,36}[r-1] in the top byte.
- Forward step to round r: N0 = W0^SubWord(RotWord(W3))^Rcon(r); N1 = W1^N0; N2 = W2^N1; N3 = W3^N2.
- Inverse step from round r to r-1: P3 = W3^W2; P2 = W2^W1; P1 = W1^W0; P0 = W0^SubWord(RotWord(P3))^Rcon(r).
- IDLE: when start=1 at edge T, capture input_key, round counter = 0, go to EXPAND. busy rises after edge T.
- EXPAND: one forward step per cycle, counter incrementing. At edge T+10 the key equals round key 10. At that edge go to EMIT with valid=1, round_idx=10. Latency from sampled start to first valid is 10 cycles.
- EMIT, handshake:
  - round_key and round_idx are held stable while valid & !ready.
  - On valid & ready with idx>0: apply the inverse step, idx decrements, valid stays 1. With ready held high there is back-to-back throughput of one key per cycle.
  - On valid & ready with idx==0: valid=0, busy=0, done=1 for one cycle, return to IDLE.
- start while busy is ignored, with no effect on the in-flight sequence. start coincident with a done pulse is also ignored; start is accepted only when the state is IDLE.
- ready while valid=0 has no effect.
- Reset mid-operation (EXPAND or EMIT): immediate abort, all outputs to reset values, no done pulse.
- input_key is sampled only at start acceptance; later changes to it have no effect.
- Arithmetic is XOR only; round_idx never wraps below 0 and never exceeds 10.

Decomposition:
- Shared package/include aes_pkg:
  - Rcon table as a 10-entry byte constant function.
  - State encodings IDLE/EXPAND/EMIT.
  - NR constant.
  - Round-key width (128) and word width (32) constants.
- Sub-module aes_sub_word (4 parallel S-box lookups, 32-bit in/out). A single instance is shared: its input is muxed between W3 (EXPAND) and W3^W2 (EMIT).

Test Plan:
- Reset: assert rst mid-simulation -> all outputs 0 asynchronously, before the next clock edge.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, ready=1:
  - valid rises exactly 10 cycles after start with idx 10, key d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Next cycle: idx 9, key ac7766f319fadc2128d12941575c006e.
  - idx 1: a0fafe1788542cb123a339392a6c7605.
  - idx 0: 2b7e151628aed2a6abf7158809cf4f3c.
  - 11 consecutive valid cycles, then one done pulse.
- Backpressure: same key, ready=0 for 3 cycles while idx=9 -> key ac7766f3... and idx 9 held unchanged; sequence resumes correctly when ready returns.
- Start while busy: pulse start with a different key during EXPAND and again during EMIT -> output sequence identical to the FIPS case, and exactly one done.
- Reset mid-EMIT at idx 5 -> valid=0, busy=0, no done. A new start with the FIPS key afterwards yields the full correct sequence.
- All-zero key -> idx 10 key b4ef5bcb3e92e21123e951cf6f8f188e, idx 1 key 62636363626363636263636362636363, idx 0 key all zeros.
